// File: rtl/matrix_row_loader_pkg.sv
// Shared types and default sizing for the matrix row loader.
// Elements are fp16 words packed four to a scratchpad row.
package matrix_row_loader_pkg;

    localparam int DEF_ELEM_W    = 16;
    localparam int DEF_ROW_ELEMS = 4;
    localparam int DEF_MAT_ROWS  = 4;
    localparam int DEF_NUM_MATS  = 4;

    typedef logic [DEF_ELEM_W-1:0] elem_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } loader_state_t;

endpackage

// File: rtl/matrix_row_loader_if.sv
// FIFO read side and scratchpad write side of the row loader.
// master = loader, slave = FIFO/scratchpad environment.
interface matrix_row_loader_if
    import matrix_row_loader_pkg::*;
#(
    parameter int ELEM_W    = DEF_ELEM_W,
    parameter int ROW_ELEMS = DEF_ROW_ELEMS,
    parameter int MAT_ROWS  = DEF_MAT_ROWS,
    parameter int NUM_MATS  = DEF_NUM_MATS
);

    logic                          fifo_empty;
    logic [ELEM_W-1:0]             fifo_rdata;
    logic                          fifo_ren;
    logic                          wen;
    logic [$clog2(NUM_MATS)-1:0]   w_mat_sel;
    logic [$clog2(MAT_ROWS)-1:0]   w_row_sel;
    logic [ELEM_W*ROW_ELEMS-1:0]   wdat;

    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        output fifo_ren,
        output wen,
        output w_mat_sel,
        output w_row_sel,
        output wdat
    );

    modport slave (
        output fifo_empty,
        output fifo_rdata,
        input  fifo_ren,
        input  wen,
        input  w_mat_sel,
        input  w_row_sel,
        input  wdat
    );

endinterface

// File: rtl/matrix_row_loader.sv
// Drains the element FIFO and packs elements into scratchpad rows.
// One start loads a whole matrix, row 0 first, one element per cycle.
module matrix_row_loader
    import matrix_row_loader_pkg::*;
#(
    parameter int ELEM_W    = DEF_ELEM_W,
    parameter int ROW_ELEMS = DEF_ROW_ELEMS,
    parameter int MAT_ROWS  = DEF_MAT_ROWS,
    parameter int NUM_MATS  = DEF_NUM_MATS
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        start,
    input  logic [$clog2(NUM_MATS)-1:0] mat_sel,
    matrix_row_loader_if.master         bus,
    output logic                        busy,
    output logic                        done
);

    localparam int EW = $clog2(ROW_ELEMS);
    localparam int RW = $clog2(MAT_ROWS);
    localparam logic [EW-1:0] ELEM_LAST = EW'(ROW_ELEMS - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(MAT_ROWS - 1);

    loader_state_t state;
    loader_state_t state_n;

    logic [EW-1:0]               elem_cnt;
    logic [RW-1:0]               row_cnt;
    logic [ELEM_W-1:0]           row_buf [ROW_ELEMS];
    logic [ELEM_W*ROW_ELEMS-1:0] row_full;
    logic                        pop;
    logic                        row_end;
    logic                        mat_end;
    logic                        accept;

    assign accept  = (state == IDLE) && start;
    assign pop     = (state == FILL) && !bus.fifo_empty;
    assign row_end = pop && (elem_cnt == ELEM_LAST);
    assign mat_end = row_end && (row_cnt == ROW_LAST);

    assign bus.fifo_ren = pop;
    assign busy         = (state != IDLE);

    // Completed row: buffered slots plus the element being popped now.
    always_comb begin
        row_full = '0;
        for (int i = 0; i < ROW_ELEMS; i++) begin
            if (EW'(i) == elem_cnt) begin
                row_full[i*ELEM_W +: ELEM_W] = bus.fifo_rdata;
            end else begin
                row_full[i*ELEM_W +: ELEM_W] = row_buf[i];
            end
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state: load on start, finish on the last element of the last row.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = FILL;
                end
            end
            FILL: begin
                if (mat_end) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Element/row counters and the partial-row buffer.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            elem_cnt <= '0;
            row_cnt  <= '0;
            for (int i = 0; i < ROW_ELEMS; i++) begin
                row_buf[i] <= '0;
            end
        end else if (accept) begin
            elem_cnt <= '0;
            row_cnt  <= '0;
        end else if (pop) begin
            row_buf[elem_cnt] <= bus.fifo_rdata;
            if (row_end) begin
                elem_cnt <= '0;
                row_cnt  <= row_cnt + 1'b1;
            end else begin
                elem_cnt <= elem_cnt + 1'b1;
            end
        end
    end

    // Registered write stage and completion pulse.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bus.wen       <= 1'b0;
            bus.w_mat_sel <= '0;
            bus.w_row_sel <= '0;
            bus.wdat      <= '0;
            done          <= 1'b0;
        end else begin
            bus.wen <= row_end;
            done    <= mat_end;
            if (accept) begin
                bus.w_mat_sel <= mat_sel;
            end
            if (row_end) begin
                bus.wdat      <= row_full;
                bus.w_row_sel <= row_cnt;
            end
        end
    end

endmodule

// File: tb/tb_matrix_row_loader.sv
// Scoreboard bench for matrix_row_loader with a behavioural FIFO
// upstream and a write monitor standing in for the scratchpad.
module tb_matrix_row_loader;

    typedef struct {
        logic [1:0]  mat;
        logic [1:0]  row;
        logic [63:0] data;
    } exp_t;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       start;
    logic [1:0] mat_sel;
    logic       busy;
    logic       done;

    matrix_row_loader_if bus_if ();

    matrix_row_loader dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .start   (start),
        .mat_sel (mat_sel),
        .bus     (bus_if),
        .busy    (busy),
        .done    (done)
    );

    always #5 CLK = ~CLK;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   done_cnt = 0;

    exp_t        sb[$];
    logic [15:0] stream[$];
    int          wen_q[$];
    int          done_q[$];

    logic [15:0] mem [1024];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    logic flush_req = 1'b0;
    logic underrun  = 1'b0;
    logic hold_man  = 1'b0;
    logic hold_rnd  = 1'b0;
    logic rand_gaps = 1'b0;

    assign bus_if.fifo_empty = (rd_ptr == wr_ptr) || hold_man || hold_rnd;
    assign bus_if.fifo_rdata = mem[rd_ptr];

    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural FIFO pop side.
    always @(posedge CLK) begin
        if (flush_req) begin
            rd_ptr <= wr_ptr;
        end else if (bus_if.fifo_ren) begin
            if (bus_if.fifo_empty) underrun <= 1'b1;
            else rd_ptr <= rd_ptr + 1;
        end
    end

    // Random stall generator.
    always @(negedge CLK) begin
        hold_rnd <= rand_gaps && ($urandom_range(0, 3) == 0);
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at cyc %0d",
                     nm, act, exp, cyc);
        end
    endtask

    // Write monitor: every row write is checked against the scoreboard.
    always @(negedge CLK) begin
        if (nRST) begin
            if (bus_if.wen) begin
                wen_q.push_back(cyc);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL wen_unexpected: got row %0d want none",
                             bus_if.w_row_sel);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("w_mat_sel", 64'(bus_if.w_mat_sel), 64'(e.mat));
                    chk("w_row_sel", 64'(bus_if.w_row_sel), 64'(e.row));
                    chk("wdat", bus_if.wdat, e.data);
                    chk("done_with_row", 64'(done), 64'(e.row == 2'd3));
                end
            end else if (done) begin
                n_cmp++;
                n_fail++;
                $display("FAIL done_unexpected: got 1 want 0");
            end
            if (done) begin
                done_q.push_back(cyc);
                done_cnt++;
            end
            if (bus_if.fifo_ren) begin
                chk("ren_while_empty", 64'(bus_if.fifo_empty), 64'd0);
            end
        end
    end

    task automatic gen(input int n);
        logic [31:0] v;
        for (int i = 0; i < n; i++) begin
            v = $urandom;
            stream.push_back(v[15:0]);
            mem[wr_ptr + i] = v[15:0];
        end
    endtask

    task automatic feed(input int n);
        wr_ptr = wr_ptr + n;
    endtask

    task automatic gen_seq();
        for (int i = 0; i < 16; i++) begin
            stream.push_back(16'(i + 1));
            mem[wr_ptr + i] = 16'(i + 1);
        end
    endtask

    // Called at a negedge; returns the edge that sampled start.
    task automatic start_load(input logic [1:0] m, output int e0);
        exp_t e;
        start   = 1'b1;
        mat_sel = m;
        for (int r = 0; r < 4; r++) begin
            e.mat  = m;
            e.row  = 2'(r);
            e.data = '0;
            for (int j = 0; j < 4; j++) begin
                e.data[j*16 +: 16] = stream.pop_front();
            end
            sb.push_back(e);
        end
        @(negedge CLK);
        start = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_sb(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk("sb_drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    initial begin
        int e0;
        int e1;
        int r0;
        int dc;

        nRST    = 1'b0;
        start   = 1'b0;
        mat_sel = '0;
        repeat (2) @(negedge CLK);
        chk("rst_fifo_ren", 64'(bus_if.fifo_ren), 64'd0);
        chk("rst_wen", 64'(bus_if.wen), 64'd0);
        chk("rst_w_mat_sel", 64'(bus_if.w_mat_sel), 64'd0);
        chk("rst_w_row_sel", 64'(bus_if.w_row_sel), 64'd0);
        chk("rst_wdat", bus_if.wdat, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        nRST = 1'b1;
        @(negedge CLK);

        // Basic load of 1..16 into matrix 2.
        gen_seq();
        feed(16);
        wen_q.delete();
        done_q.delete();
        start_load(2'd2, e0);
        while (cyc < e0 + 16) @(negedge CLK);
        chk("busy_at_done", 64'(busy), 64'd1);
        @(negedge CLK);
        chk("busy_after_done", 64'(busy), 64'd0);
        wait_sb(10);
        for (int r = 0; r < 4; r++) begin
            chk("basic_wen_cyc", 64'(wen_q[r]), 64'(e0 + 4*r + 4));
        end
        chk("basic_done_cyc", 64'(done_q[0]), 64'(e0 + 16));
        wait_idle(10);
        @(negedge CLK);

        // Three-cycle FIFO gap after element 6.
        gen(16);
        feed(16);
        wen_q.delete();
        start_load(2'd0, e0);
        while (cyc < e0 + 6) @(negedge CLK);
        hold_man = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("gap_ren", 64'(bus_if.fifo_ren), 64'd0);
            @(negedge CLK);
        end
        hold_man = 1'b0;
        wait_sb(40);
        chk("gap_row0_cyc", 64'(wen_q[0]), 64'(e0 + 4));
        chk("gap_row1_cyc", 64'(wen_q[1]), 64'(e0 + 11));
        chk("gap_row3_cyc", 64'(wen_q[3]), 64'(e0 + 19));
        wait_idle(10);
        @(negedge CLK);

        // Start during a load is ignored.
        gen(20);
        feed(20);
        r0 = rd_ptr;
        start_load(2'd0, e0);
        while (cyc < e0 + 9) @(negedge CLK);
        start   = 1'b1;
        mat_sel = 2'd1;
        @(negedge CLK);
        start = 1'b0;
        wait_sb(40);
        wait_idle(10);
        repeat (3) @(negedge CLK);
        chk("ignored_start_busy", 64'(busy), 64'd0);
        chk("ignored_start_pops", 64'(rd_ptr - r0), 64'd16);

        // Reset mid-load after element 7.
        gen(12);
        feed(12);
        start_load(2'd1, e0);
        while (cyc < e0 + 7) @(negedge CLK);
        nRST = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ren", 64'(bus_if.fifo_ren), 64'd0);
        chk("midrst_wdat", bus_if.wdat, 64'd0);
        chk("midrst_w_mat_sel", 64'(bus_if.w_mat_sel), 64'd0);
        sb.delete();
        stream.delete();
        flush_req = 1'b1;
        dc = done_cnt;
        repeat (2) @(negedge CLK);
        flush_req = 1'b0;
        nRST = 1'b1;
        repeat (4) @(negedge CLK);
        chk("midrst_no_done", 64'(done_cnt), 64'(dc));
        gen(16);
        feed(16);
        start_load(2'd3, e0);
        wait_sb(40);
        wait_idle(10);
        chk("after_rst_done", 64'(done_cnt), 64'(dc + 1));
        @(negedge CLK);

        // Back-to-back loads from one 32-element fill.
        gen(32);
        feed(32);
        done_q.delete();
        start_load(2'd1, e0);
        wait_idle(40);
        start_load(2'd2, e1);
        wait_sb(40);
        wait_idle(10);
        chk("b2b_done_count", 64'(done_q.size()), 64'd2);
        chk("b2b_done0_cyc", 64'(done_q[0]), 64'(e0 + 16));
        chk("b2b_done1_cyc", 64'(done_q[1]), 64'(e1 + 16));
        @(negedge CLK);

        // Empty FIFO held after start.
        gen(16);
        start_load(2'd3, e0);
        repeat (20) @(negedge CLK);
        chk("empty_ren", 64'(bus_if.fifo_ren), 64'd0);
        chk("empty_busy", 64'(busy), 64'd1);
        chk("empty_underrun", 64'(underrun), 64'd0);
        feed(16);
        wait_sb(40);
        wait_idle(10);
        @(negedge CLK);

        // Randomised loads with random stalls.
        rand_gaps = 1'b1;
        for (int t = 0; t < 6; t++) begin
            gen(16);
            feed(16);
            start_load(2'($urandom_range(0, 3)), e0);
            wait_sb(200);
            wait_idle(20);
            @(negedge CLK);
        end
        rand_gaps = 1'b0;
        repeat (3) @(negedge CLK);
        chk("final_underrun", 64'(underrun), 64'd0);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
